// File: rtl/reg_file_wb_if.sv
// Bus bundle for the write-back register file: write request path,
// error-counter control and the two combinational read ports.
interface reg_file_wb_if #(
    parameter int WIDTH = 16
);
    logic             wr_req;
    logic [15:0]      rseln;
    logic [WIDTH-1:0] wr_data;
    logic [3:0]       rd_a_sel;
    logic [3:0]       rd_b_sel;
    logic             err_clr;
    logic [WIDTH-1:0] rd_a_data;
    logic [WIDTH-1:0] rd_b_data;
    logic             wr_ack;
    logic             sel_err;
    logic [3:0]       err_cnt;

    modport master (
        output wr_req, rseln, wr_data, rd_a_sel, rd_b_sel, err_clr,
        input  rd_a_data, rd_b_data, wr_ack, sel_err, err_cnt
    );

    modport slave (
        input  wr_req, rseln, wr_data, rd_a_sel, rd_b_sel, err_clr,
        output rd_a_data, rd_b_data, wr_ack, sel_err, err_cnt
    );
endinterface

// File: rtl/reg_file_wb.sv
// Write-back register file fed by the active-low one-hot write-select
// decoder. A write is validated and encoded, parked for one cycle in a
// pending stage (forwarded to both read ports), then committed to the
// 16-entry array. Malformed select vectors are rejected and counted.
module reg_file_wb #(
    // Read-output settling time used by gate-level datapath models; the
    // RTL read path is zero-delay combinational.
    parameter real NAND_TIME = 7.0,
    parameter int  WIDTH     = 16,
    parameter int  ZERO_R0   = 0
) (
    input logic         clk,
    input logic         rst,
    reg_file_wb_if.slave bus
);

    // Exactly one low bit in the select vector marks a legal write.
    function automatic logic sel_valid(input logic [15:0] sel_n);
        logic [4:0] zeros;
        zeros = '0;
        for (int i = 0; i < 16; i++) begin
            zeros = zeros + {4'd0, ~sel_n[i]};
        end
        return (zeros == 5'd1);
    endfunction

    // Position of the low bit; only meaningful when sel_valid holds.
    function automatic logic [3:0] sel_index(input logic [15:0] sel_n);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (!sel_n[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // Error counter saturates at all-ones rather than wrapping.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // Pending-stage forwarding, then array lookup; register 0 is
    // hard-wired to zero when ZERO_R0 is set.
    function automatic logic [WIDTH-1:0] read_mux(
        input logic [3:0]       sel,
        input logic             vld,
        input logic [3:0]       idx,
        input logic [WIDTH-1:0] pdata,
        input logic [WIDTH-1:0] arr_val
    );
        logic [WIDTH-1:0] r;
        if (ZERO_R0 != 0 && sel == 4'd0) begin
            r = '0;
        end else if (vld && idx == sel) begin
            r = pdata;
        end else begin
            r = arr_val;
        end
        return r;
    endfunction

    logic             sel_ok_p0;
    logic [3:0]       sel_idx_p0;

    logic             pend_vld_p1;
    logic [3:0]       pend_idx_p1;
    logic [WIDTH-1:0] pend_data_p1;
    logic             wr_ack_p1;
    logic             sel_err_q;
    logic [3:0]       err_cnt_q;

    logic [WIDTH-1:0] regs [16];
    logic             commit_en;

    // ---- stage p0: decode the incoming select vector ----
    // Validate and encode the one-hot select combinationally.
    always_comb begin
        sel_ok_p0  = sel_valid(bus.rseln);
        sel_idx_p0 = sel_index(bus.rseln);
    end

    // ---- stage p1: pending write and error bookkeeping ----
    // Pending-stage control, write acknowledge and error tracking; a
    // reject on the same edge as err_clr takes precedence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_vld_p1 <= 1'b0;
            pend_idx_p1 <= '0;
            wr_ack_p1   <= 1'b0;
            sel_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            if (bus.wr_req && sel_ok_p0) begin
                pend_vld_p1 <= 1'b1;
                pend_idx_p1 <= sel_idx_p0;
                wr_ack_p1   <= 1'b1;
            end else begin
                pend_vld_p1 <= 1'b0;
                wr_ack_p1   <= 1'b0;
            end

            if (bus.wr_req && !sel_ok_p0) begin
                sel_err_q <= 1'b1;
                err_cnt_q <= bus.err_clr ? 4'd1 : sat_inc(err_cnt_q);
            end else if (bus.err_clr) begin
                sel_err_q <= 1'b0;
                err_cnt_q <= '0;
            end
        end
    end

    // Pending data only matters while pend_vld_p1 is set, so it is not reset.
    always_ff @(posedge clk) begin
        if (bus.wr_req && sel_ok_p0) begin
            pend_data_p1 <= bus.wr_data;
        end
    end

    // ---- stage p2: commit to the array ----
    assign commit_en = pend_vld_p1 && !(ZERO_R0 != 0 && pend_idx_p1 == 4'd0);

    // Commit the pending write; runs alongside the next capture so
    // back-to-back writes never stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else if (commit_en) begin
            regs[pend_idx_p1] <= pend_data_p1;
        end
    end

    // Two independent read ports with pending-stage forwarding.
    always_comb begin
        bus.rd_a_data = read_mux(bus.rd_a_sel, pend_vld_p1, pend_idx_p1,
                                 pend_data_p1, regs[bus.rd_a_sel]);
        bus.rd_b_data = read_mux(bus.rd_b_sel, pend_vld_p1, pend_idx_p1,
                                 pend_data_p1, regs[bus.rd_b_sel]);
    end

    assign bus.wr_ack  = wr_ack_p1;
    assign bus.sel_err = sel_err_q;
    assign bus.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_reg_file_wb.sv
// Self-checking bench for reg_file_wb. The reference model tracks the
// architecturally visible register contents (a write is visible right
// after its capture edge), the ack pulse and the saturating error count.
module tb_reg_file_wb;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    reg_file_wb_if #(.WIDTH(16)) bus0 ();
    reg_file_wb_if #(.WIDTH(16)) bus1 ();

    reg_file_wb #(.NAND_TIME(7.0), .WIDTH(16), .ZERO_R0(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    reg_file_wb #(.NAND_TIME(7.0), .WIDTH(16), .ZERO_R0(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state for dut0
    logic [15:0] m_reg [16];
    logic        m_ack;
    logic        m_err;
    int          m_cnt;

    function automatic int count_zeros(input logic [15:0] v);
        int c;
        c = 0;
        for (int i = 0; i < 16; i++) if (v[i] == 1'b0) c++;
        return c;
    endfunction

    function automatic int low_pos(input logic [15:0] v);
        int p;
        p = 0;
        for (int i = 0; i < 16; i++) if (v[i] == 1'b0) p = i;
        return p;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_reg[i] = 16'h0;
        m_ack = 1'b0;
        m_err = 1'b0;
        m_cnt = 0;
    endtask

    task automatic model_edge(input logic req, input logic [15:0] sel,
                              input logic [15:0] data, input logic clr);
        if (clr) begin
            m_err = 1'b0;
            m_cnt = 0;
        end
        if (req && count_zeros(sel) == 1) begin
            m_reg[low_pos(sel)] = data;
            m_ack = 1'b1;
        end else begin
            m_ack = 1'b0;
            if (req) begin
                m_err = 1'b1;
                m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
            end
        end
    endtask

    // Present one request to dut0, clock it, and advance the model.
    task automatic drive(input logic req, input logic [15:0] sel,
                         input logic [15:0] data, input logic clr);
        bus0.wr_req  = req;
        bus0.rseln   = sel;
        bus0.wr_data = data;
        bus0.err_clr = clr;
        @(posedge clk);
        #1;
        model_edge(req, sel, data, clr);
    endtask

    task automatic idle0();
        bus0.wr_req  = 1'b0;
        bus0.rseln   = 16'hFFFF;
        bus0.wr_data = 16'h0;
        bus0.err_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle0();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 16; i++) begin
            bus0.rd_a_sel = 4'(i);
            bus0.rd_b_sel = 4'(15 - i);
            #1;
            n_cmp++;
            if (bus0.rd_a_data !== m_reg[i]) begin
                n_fail++;
                $display("FAIL reset_rd_a idx=%0d got=%h exp=%h", i, bus0.rd_a_data, m_reg[i]);
            end
            n_cmp++;
            if (bus0.rd_b_data !== m_reg[15 - i]) begin
                n_fail++;
                $display("FAIL reset_rd_b idx=%0d got=%h exp=%h", 15 - i, bus0.rd_b_data, m_reg[15 - i]);
            end
        end
        n_cmp++;
        if (bus0.wr_ack !== 1'b0 || bus0.sel_err !== 1'b0 || bus0.err_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl got ack=%b err=%b cnt=%0d exp 0/0/0",
                     bus0.wr_ack, bus0.sel_err, bus0.err_cnt);
        end
    endtask

    task automatic test_single_write();
        bus0.rd_a_sel = 4'd3;
        drive(1'b1, 16'hFFF7, 16'hBEEF, 1'b0);
        n_cmp++;
        if (bus0.rd_a_data !== 16'hBEEF || m_reg[3] !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL single_bypass got=%h exp=%h", bus0.rd_a_data, 16'hBEEF);
        end
        n_cmp++;
        if (bus0.wr_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ack_hi got=%b exp=1", bus0.wr_ack);
        end
        drive(1'b0, 16'hFFF7, 16'h0000, 1'b0);
        n_cmp++;
        if (bus0.wr_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ack_lo got=%b exp=0", bus0.wr_ack);
        end
        drive(1'b0, 16'hFFFF, 16'h0000, 1'b0);
        n_cmp++;
        if (bus0.rd_a_data !== m_reg[3]) begin
            n_fail++;
            $display("FAIL single_array got=%h exp=%h", bus0.rd_a_data, m_reg[3]);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_b [3];
        exp_b[0] = 16'h1111;
        exp_b[1] = 16'h2222;
        exp_b[2] = 16'h2222;
        bus0.rd_b_sel = 4'd5;
        drive(1'b1, ~(16'h0001 << 5), 16'h1111, 1'b0);
        n_cmp++;
        if (bus0.rd_b_data !== exp_b[0]) begin
            n_fail++;
            $display("FAIL b2b_step0 got=%h exp=%h", bus0.rd_b_data, exp_b[0]);
        end
        drive(1'b1, ~(16'h0001 << 5), 16'h2222, 1'b0);
        n_cmp++;
        if (bus0.rd_b_data !== exp_b[1]) begin
            n_fail++;
            $display("FAIL b2b_step1 got=%h exp=%h", bus0.rd_b_data, exp_b[1]);
        end
        drive(1'b1, ~(16'h0001 << 9), 16'h3333, 1'b0);
        n_cmp++;
        if (bus0.rd_b_data !== exp_b[2] || bus0.wr_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_step2 got=%h ack=%b exp=%h ack=1", bus0.rd_b_data, bus0.wr_ack, exp_b[2]);
        end
        drive(1'b0, 16'hFFFF, 16'h0, 1'b0);
        drive(1'b0, 16'hFFFF, 16'h0, 1'b0);
        bus0.rd_a_sel = 4'd9;
        #1;
        n_cmp++;
        if (bus0.rd_b_data !== m_reg[5] || m_reg[5] !== 16'h2222) begin
            n_fail++;
            $display("FAIL b2b_reg5 got=%h exp=%h", bus0.rd_b_data, 16'h2222);
        end
        n_cmp++;
        if (bus0.rd_a_data !== m_reg[9] || m_reg[9] !== 16'h3333) begin
            n_fail++;
            $display("FAIL b2b_reg9 got=%h exp=%h", bus0.rd_a_data, 16'h3333);
        end
    endtask

    task automatic test_invalid_sel();
        bus0.rd_a_sel = 4'd0;
        bus0.rd_b_sel = 4'd13;
        drive(1'b1, 16'hFFFF, 16'hDEAD, 1'b0);
        n_cmp++;
        if (bus0.sel_err !== 1'b1 || bus0.err_cnt !== 4'(m_cnt) || m_cnt != 1) begin
            n_fail++;
            $display("FAIL inv_none got err=%b cnt=%0d exp err=1 cnt=1", bus0.sel_err, bus0.err_cnt);
        end
        n_cmp++;
        if (bus0.wr_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL inv_none_ack got=%b exp=0", bus0.wr_ack);
        end
        drive(1'b1, 16'hDFFE, 16'hDEAD, 1'b0);
        n_cmp++;
        if (bus0.err_cnt !== 4'(m_cnt) || m_cnt != 2) begin
            n_fail++;
            $display("FAIL inv_two got cnt=%0d exp=2", bus0.err_cnt);
        end
        n_cmp++;
        if (bus0.rd_a_data !== m_reg[0] || bus0.rd_b_data !== m_reg[13]) begin
            n_fail++;
            $display("FAIL inv_nowrite got a=%h b=%h exp a=%h b=%h",
                     bus0.rd_a_data, bus0.rd_b_data, m_reg[0], m_reg[13]);
        end
        for (int i = 0; i < 20; i++) drive(1'b1, 16'hDFFE, 16'hDEAD, 1'b0);
        n_cmp++;
        if (bus0.err_cnt !== 4'd15 || bus0.sel_err !== 1'b1) begin
            n_fail++;
            $display("FAIL inv_saturate got cnt=%0d err=%b exp cnt=15 err=1", bus0.err_cnt, bus0.sel_err);
        end
    endtask

    task automatic test_err_clr();
        drive(1'b1, 16'hDFFE, 16'h0, 1'b1);
        n_cmp++;
        if (bus0.sel_err !== 1'b1 || bus0.err_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL clr_with_reject got err=%b cnt=%0d exp err=1 cnt=1", bus0.sel_err, bus0.err_cnt);
        end
        drive(1'b0, 16'hFFFF, 16'h0, 1'b1);
        n_cmp++;
        if (bus0.sel_err !== 1'b0 || bus0.err_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL clr_alone got err=%b cnt=%0d exp err=0 cnt=0", bus0.sel_err, bus0.err_cnt);
        end
        drive(1'b0, 16'h0000, 16'h0, 1'b0);
        n_cmp++;
        if (bus0.sel_err !== m_err || bus0.err_cnt !== 4'(m_cnt) || bus0.wr_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_badsel got err=%b cnt=%0d ack=%b exp err=0 cnt=0 ack=0",
                     bus0.sel_err, bus0.err_cnt, bus0.wr_ack);
        end
    endtask

    task automatic test_reset_inflight();
        bus0.rd_a_sel = 4'd12;
        drive(1'b1, ~(16'h0001 << 12), 16'hA5A5, 1'b0);
        idle0();
        rst = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if (bus0.rd_a_data !== 16'h0000 || bus0.wr_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_inflight got rd=%h ack=%b exp rd=0000 ack=0", bus0.rd_a_data, bus0.wr_ack);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 16'hFFFF, 16'h0, 1'b0);
        n_cmp++;
        if (bus0.rd_a_data !== m_reg[12]) begin
            n_fail++;
            $display("FAIL rst_dropped got=%h exp=%h", bus0.rd_a_data, m_reg[12]);
        end
    endtask

    task automatic test_zero_r0();
        bus1.rd_a_sel = 4'd0;
        bus1.rd_b_sel = 4'd1;
        bus1.wr_req   = 1'b1;
        bus1.rseln    = 16'hFFFE;
        bus1.wr_data  = 16'h7777;
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus1.wr_ack !== 1'b1 || bus1.rd_a_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL z0_capture got ack=%b rd=%h exp ack=1 rd=0000", bus1.wr_ack, bus1.rd_a_data);
        end
        bus1.rseln   = 16'hFFFD;
        bus1.wr_data = 16'h1234;
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus1.rd_b_data !== 16'h1234 || bus1.rd_a_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL z0_reg1 got a=%h b=%h exp a=0000 b=1234", bus1.rd_a_data, bus1.rd_b_data);
        end
        bus1.wr_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (bus1.wr_ack !== 1'b0 || bus1.rd_a_data !== 16'h0000 || bus1.rd_b_data !== 16'h1234) begin
            n_fail++;
            $display("FAIL z0_after got ack=%b a=%h b=%h exp ack=0 a=0000 b=1234",
                     bus1.wr_ack, bus1.rd_a_data, bus1.rd_b_data);
        end
    endtask

    task automatic test_random();
        logic        req;
        logic [15:0] sel;
        logic        clr;
        for (int n = 0; n < 400; n++) begin
            req = ($urandom_range(3) != 0);
            case ($urandom_range(7))
                0:       sel = 16'($urandom);
                1:       sel = 16'hFFFF;
                default: sel = ~(16'h0001 << $urandom_range(15));
            endcase
            clr = ($urandom_range(15) == 0);
            drive(req, sel, 16'($urandom), clr);
            bus0.rd_a_sel = 4'($urandom_range(15));
            bus0.rd_b_sel = 4'($urandom_range(15));
            #1;
            n_cmp++;
            if (bus0.rd_a_data !== m_reg[bus0.rd_a_sel] || bus0.rd_b_data !== m_reg[bus0.rd_b_sel]) begin
                n_fail++;
                $display("FAIL rand_read n=%0d a[%0d]=%h exp %h b[%0d]=%h exp %h", n,
                         bus0.rd_a_sel, bus0.rd_a_data, m_reg[bus0.rd_a_sel],
                         bus0.rd_b_sel, bus0.rd_b_data, m_reg[bus0.rd_b_sel]);
            end
            n_cmp++;
            if (bus0.wr_ack !== m_ack || bus0.sel_err !== m_err || bus0.err_cnt !== 4'(m_cnt)) begin
                n_fail++;
                $display("FAIL rand_ctrl n=%0d got ack=%b err=%b cnt=%0d exp ack=%b err=%b cnt=%0d", n,
                         bus0.wr_ack, bus0.sel_err, bus0.err_cnt, m_ack, m_err, m_cnt);
            end
        end
    endtask

    initial begin
        idle0();
        bus0.rd_a_sel = 4'd0;
        bus0.rd_b_sel = 4'd0;
        bus1.wr_req   = 1'b0;
        bus1.rseln    = 16'hFFFF;
        bus1.wr_data  = 16'h0;
        bus1.err_clr  = 1'b0;
        bus1.rd_a_sel = 4'd0;
        bus1.rd_b_sel = 4'd0;
        model_reset();

        test_reset();
        test_single_write();
        test_back_to_back();
        test_invalid_sel();
        test_err_clr();
        test_reset_inflight();
        test_zero_r0();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
